// File: rtl/instruction_fetch_phase_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state codes, reset
// defaults and the redirect-source encoding used by the PC mux.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef enum logic [1:0] {
    RSEL_NONE   = 2'd0,
    RSEL_BRANCH = 2'd1,
    RSEL_JUMP   = 2'd2,
    RSEL_JREG   = 2'd3
  } redirect_sel_e;

  // jr outranks j, which outranks a taken branch
  function automatic redirect_sel_e redirect_select(input logic jreg,
                                                    input logic jump,
                                                    input logic branch);
    redirect_sel_e sel;
    if (jreg)        sel = RSEL_JREG;
    else if (jump)   sel = RSEL_JUMP;
    else if (branch) sel = RSEL_BRANCH;
    else             sel = RSEL_NONE;
    return sel;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_phase_if.sv
// Instruction-memory fetch channel: req/ready request handshake plus a
// single-cycle rvalid read-data return.
interface instruction_fetch_phase_if;

  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/instruction_fetch_phase_ifid.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with flush taking
// priority over load and stall holding the current contents.
module ifid_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_next,
  input  logic [31:0] pc_next,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr <= NOP_INSTR;
      pc    <= 32'h0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      pc    <= 32'h0;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= instr_next;
      pc    <= pc_next;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_phase.sv
// Fetch stage: owns the PC, runs one outstanding imem request at a time and
// feeds the IF/ID register. Define FETCH_STATS_EN to add fetch/stall/redirect counters.
module instruction_fetch_phase
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  instruction_fetch_phase_if.master  imem,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic                       Branch,
  input  logic [31:0]                BranchTarget,
  input  logic                       Jump,
  input  logic [31:0]                JumpTarget,
  input  logic                       JumpRegister,
  input  logic [31:0]                JumpRegTarget,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic                       ifid_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                stall_count,
  output logic [15:0]                redirect_count
`endif
);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc_inc;
  logic [31:0]   hold_buf;
  logic [31:0]   target;
  logic          kill;
  logic          kill_next;
  logic          hold_load;
  logic          ifid_load;
  logic [31:0]   ifid_instr;
  logic          handshake;
  logic          redirect;
  redirect_sel_e rsel;

  assign pc_inc    = pc + 32'd4;
  assign rsel      = redirect_select(JumpRegister, Jump, Branch);
  assign redirect  = !Stall && (rsel != RSEL_NONE);

  // A stalled stage issues nothing new; the address still tracks pc
  assign imem.req  = (state == S_REQ) && !Stall;
  assign imem.addr = pc;
  assign handshake = imem.req && imem.ready;

  always_comb begin
    case (rsel)
      RSEL_JREG: target = JumpRegTarget;
      RSEL_JUMP: target = JumpTarget;
      default:   target = BranchTarget;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    hold_load  = 1'b0;
    ifid_load  = 1'b0;
    ifid_instr = imem.rdata;
    case (state)
      S_BOOT: state_next = S_REQ;
      S_REQ: begin
        if (handshake) begin
          state_next = S_WAIT;
          kill_next  = redirect;
        end
      end
      S_WAIT: begin
        if (imem.rvalid) begin
          if (kill || redirect) begin
            kill_next  = 1'b0;
            state_next = S_REQ;
          end else if (!Stall) begin
            ifid_load  = 1'b1;
            pc_next    = pc_inc;
            state_next = S_REQ;
          end else begin
            hold_load  = 1'b1;
            state_next = S_HOLD;
          end
        end else if (redirect) begin
          // Response still in flight: remember to discard it when it lands
          kill_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_next = S_REQ;
        end else if (!Stall) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_buf;
          pc_next    = pc_inc;
          state_next = S_REQ;
        end
      end
      default: state_next = S_BOOT;
    endcase
    if (redirect) pc_next = word_align(target);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      kill  <= kill_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (hold_load) hold_buf <= imem.rdata;
  end

  // Redirects flush IF/ID on the same edge the PC moves
  ifid_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (ifid_load),
    .hold       (Stall),
    .flush      (Flush || redirect),
    .instr_next (ifid_instr),
    .pc_next    (pc_inc),
    .instr      (instr_out),
    .pc         (pc_out),
    .valid      (ifid_valid)
  );

`ifdef FETCH_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_count    <= 32'h0;
      stall_count    <= 32'h0;
      redirect_count <= 16'h0;
    end else begin
      if (ifid_load && !Flush) fetch_count <= fetch_count + 32'd1;
      if (Stall)               stall_count <= stall_count + 32'd1;
      if (redirect)            redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Bench for instruction_fetch_phase: directed scenarios followed by a randomized
// run checked against a program-order fetch model.
module tb_instruction_fetch_phase;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        Branch = 1'b0;
  logic        Jump = 1'b0;
  logic        JumpRegister = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic [31:0] JumpTarget = 32'h0;
  logic [31:0] JumpRegTarget = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        ifid_valid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [15:0] redirect_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int ready_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  instruction_fetch_phase_if imem ();

  instruction_fetch_phase #(
    .RESET_PC  (32'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .imem          (imem),
    .Stall         (Stall),
    .Flush         (Flush),
    .Branch        (Branch),
    .BranchTarget  (BranchTarget),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .JumpRegister  (JumpRegister),
    .JumpRegTarget (JumpRegTarget),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .redirect_count (redirect_count)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  // Instruction memory: accepts on req&ready, answers after lat_min..lat_max cycles
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    imem.ready = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = 32'h0;
    forever begin
      @(posedge Clk);
      if (!Reset) pend = 1'b0;
      else if (imem.req && imem.ready) begin
        pend = 1'b1;
        paddr = imem.addr;
        cnt = int'($urandom_range(lat_max, lat_min));
      end
      @(negedge Clk);
      imem.rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem.rvalid = 1'b1;
          imem.rdata = mem_word(paddr);
          pend = 1'b0;
        end else cnt--;
      end
      imem.ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req} !== {NOP, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got instr=%h pc=%h valid=%b req=%b, want %h 0 0 0",
               instr_out, pc_out, ifid_valid, imem.req, NOP);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_basic();
    step();
    vectors++;
    if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL basic_first_req: got req=%b addr=%h, want 1 00000000", imem.req, imem.addr);
    end
    step();
    vectors++;
    if (imem.req !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait_no_req: got req=%b, want 0", imem.req);
    end
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req, imem.addr} !==
        {32'h2008_0005, 32'h4, 1'b1, 1'b1, 32'h4}) begin
      miscompares++;
      $display("FAIL basic_first_instr: got %h/%h/%b req=%b addr=%h, want 20080005/4/1 req=1 addr=4",
               instr_out, pc_out, ifid_valid, imem.req, imem.addr);
    end
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid} !== {32'h2009_0003, 32'h8, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_second_instr: got %h/%h/%b, want 20090003/8/1",
               instr_out, pc_out, ifid_valid);
    end
  endtask

  task automatic test_stall();
    step();
    @(negedge Clk);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({instr_out, pc_out, ifid_valid, imem.req} !== {32'h2009_0003, 32'h8, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%b req=%b, want 20090003/8/1 req=0",
                 i, instr_out, pc_out, ifid_valid, imem.req);
      end
    end
    @(negedge Clk);
    Stall = 1'b0;
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req, imem.addr} !==
        {mem_word(32'h8), 32'hC, 1'b1, 1'b1, 32'hC}) begin
      miscompares++;
      $display("FAIL stall_release: got %h/%h/%b req=%b addr=%h, want %h/c/1 req=1 addr=c",
               instr_out, pc_out, ifid_valid, imem.req, imem.addr, mem_word(32'h8));
    end
  endtask

  task automatic test_branch_wait();
    lat_min = 3;
    lat_max = 3;
    step();
    @(negedge Clk);
    Branch = 1'b1;
    BranchTarget = 32'h40;
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req} !== {NOP, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_flush: got %h/%h/%b req=%b, want nop/0/0 req=0",
               instr_out, pc_out, ifid_valid, imem.req);
    end
    @(negedge Clk);
    Branch = 1'b0;
    step();
    step();
    vectors++;
    if ({ifid_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h40}) begin
      miscompares++;
      $display("FAIL branch_target_req: got valid=%b req=%b addr=%h, want 0 1 00000040",
               ifid_valid, imem.req, imem.addr);
    end
    lat_min = 1;
    lat_max = 1;
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid} !== {mem_word(32'h40), 32'h44, 1'b1}) begin
      miscompares++;
      $display("FAIL branch_target_instr: got %h/%h/%b, want %h/44/1",
               instr_out, pc_out, ifid_valid, mem_word(32'h40));
    end
  endtask

  task automatic test_priority();
    @(negedge Clk);
    JumpRegister = 1'b1;
    JumpRegTarget = 32'h100;
    Jump = 1'b1;
    JumpTarget = 32'h200;
    Branch = 1'b1;
    BranchTarget = 32'h300;
    step();
    vectors++;
    if (ifid_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL priority_flush: got valid=%b, want 0", ifid_valid);
    end
    @(negedge Clk);
    JumpRegister = 1'b0;
    Jump = 1'b0;
    Branch = 1'b0;
    step();
    vectors++;
    if ({ifid_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL priority_addr: got valid=%b req=%b addr=%h, want 0 1 00000100",
               ifid_valid, imem.req, imem.addr);
    end
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid} !== {mem_word(32'h100), 32'h104, 1'b1}) begin
      miscompares++;
      $display("FAIL priority_instr: got %h/%h/%b, want %h/104/1",
               instr_out, pc_out, ifid_valid, mem_word(32'h100));
    end
  endtask

  task automatic test_stall_redirect_flush();
    @(negedge Clk);
    Stall = 1'b1;
    Branch = 1'b1;
    BranchTarget = 32'h300;
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req, imem.addr} !==
        {mem_word(32'h100), 32'h104, 1'b1, 1'b0, 32'h104}) begin
      miscompares++;
      $display("FAIL stalled_branch_ignored: got %h/%h/%b req=%b addr=%h, want %h/104/1 req=0 addr=104",
               instr_out, pc_out, ifid_valid, imem.req, imem.addr, mem_word(32'h100));
    end
    @(negedge Clk);
    Branch = 1'b0;
    Flush = 1'b1;
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.addr} !== {NOP, 32'h0, 1'b0, 32'h104}) begin
      miscompares++;
      $display("FAIL stalled_flush: got %h/%h/%b addr=%h, want nop/0/0 addr=104",
               instr_out, pc_out, ifid_valid, imem.addr);
    end
    @(negedge Clk);
    Flush = 1'b0;
    Stall = 1'b0;
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid} !== {mem_word(32'h104), 32'h108, 1'b1}) begin
      miscompares++;
      $display("FAIL resume_after_flush: got %h/%h/%b, want %h/108/1",
               instr_out, pc_out, ifid_valid, mem_word(32'h104));
    end
  endtask

  task automatic test_flush_load();
    step();
    @(negedge Clk);
    Flush = 1'b1;
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req, imem.addr} !==
        {NOP, 32'h0, 1'b0, 1'b1, 32'h10C}) begin
      miscompares++;
      $display("FAIL flush_wins_load: got %h/%h/%b req=%b addr=%h, want nop/0/0 req=1 addr=10c",
               instr_out, pc_out, ifid_valid, imem.req, imem.addr);
    end
    @(negedge Clk);
    Flush = 1'b0;
  endtask

  task automatic test_wrap();
    Jump = 1'b1;
    JumpTarget = 32'hFFFF_FFFF;
    step();
    @(negedge Clk);
    Jump = 1'b0;
    step();
    vectors++;
    if ({imem.req, imem.addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL wrap_aligned_target: got req=%b addr=%h, want 1 fffffffc", imem.req, imem.addr);
    end
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.addr} !==
        {mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL pc_wrap: got %h/%h/%b addr=%h, want %h/0/1 addr=0",
               instr_out, pc_out, ifid_valid, imem.addr, mem_word(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_ready_reset();
    ready_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
        miscompares++;
        $display("FAIL req_stable[%0d]: got req=%b addr=%h, want 1 00000000", i, imem.req, imem.addr);
      end
    end
    ready_pct = 100;
    lat_min = 3;
    lat_max = 3;
    step();
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if ({instr_out, pc_out, ifid_valid, imem.req} !== {NOP, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%h/%b req=%b, want nop/0/0 req=0",
               instr_out, pc_out, ifid_valid, imem.req);
    end
    @(posedge Clk);
    @(negedge Clk);
    lat_min = 1;
    lat_max = 1;
    Reset = 1'b1;
    step();
    vectors++;
    if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL refetch_reset_pc: got req=%b addr=%h, want 1 00000000", imem.req, imem.addr);
    end
    step();
    step();
    vectors++;
    if ({instr_out, pc_out, ifid_valid} !== {32'h2008_0005, 32'h4, 1'b1}) begin
      miscompares++;
      $display("FAIL refetch_instr: got %h/%h/%b, want 20080005/4/1", instr_out, pc_out, ifid_valid);
    end
  endtask

  // Model: instructions leave in program order from exp_next; an accepted
  // redirect empties IF/ID and restarts the order at the aligned target.
  task automatic test_random();
    logic [31:0] exp_next;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    logic [31:0] prev_addr;
    logic [31:0] tgt;
    logic        prev_valid;
    logic        was_stall;
    logic        redir;
    logic        waiting_req;
    int          loads;
    loads = 0;
    ready_pct = 70;
    lat_min = 1;
    lat_max = 3;
    exp_next = pc_out;
    prev_instr = instr_out;
    prev_pc = pc_out;
    prev_valid = ifid_valid;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Stall = (int'($urandom_range(99, 0)) < 20);
      JumpRegister = (int'($urandom_range(99, 0)) < 2);
      Jump = (int'($urandom_range(99, 0)) < 2);
      Branch = (int'($urandom_range(99, 0)) < 4);
      JumpRegTarget = $urandom_range(1023, 0);
      JumpTarget = $urandom_range(1023, 0);
      BranchTarget = $urandom_range(1023, 0);
      was_stall = Stall;
      redir = !Stall && (JumpRegister || Jump || Branch);
      tgt = JumpRegister ? JumpRegTarget : (Jump ? JumpTarget : BranchTarget);
      tgt = tgt & 32'hFFFF_FFFC;
      #1;
      prev_addr = imem.addr;
      waiting_req = imem.req && !imem.ready;
      step();
      vectors++;
      if (was_stall) begin
        if ({instr_out, pc_out, ifid_valid} !== {prev_instr, prev_pc, prev_valid}) begin
          miscompares++;
          $display("FAIL rnd_stall_hold cyc %0d: got %h/%h/%b, want %h/%h/%b",
                   i, instr_out, pc_out, ifid_valid, prev_instr, prev_pc, prev_valid);
        end
      end else if (redir) begin
        exp_next = tgt;
        if ({instr_out, pc_out, ifid_valid} !== {NOP, 32'h0, 1'b0}) begin
          miscompares++;
          $display("FAIL rnd_redirect_flush cyc %0d: got %h/%h/%b, want nop/0/0",
                   i, instr_out, pc_out, ifid_valid);
        end
      end else if (ifid_valid === 1'b1 && (!prev_valid || pc_out !== prev_pc)) begin
        loads++;
        if ({instr_out, pc_out} !== {mem_word(exp_next), exp_next + 32'd4}) begin
          miscompares++;
          $display("FAIL rnd_load_order cyc %0d: got %h/%h, want %h/%h",
                   i, instr_out, pc_out, mem_word(exp_next), exp_next + 32'd4);
        end
        exp_next = exp_next + 32'd4;
      end else if ({instr_out, pc_out, ifid_valid} !== {prev_instr, prev_pc, prev_valid}) begin
        miscompares++;
        $display("FAIL rnd_idle_hold cyc %0d: got %h/%h/%b, want %h/%h/%b",
                 i, instr_out, pc_out, ifid_valid, prev_instr, prev_pc, prev_valid);
      end
      if (waiting_req && !redir) begin
        vectors++;
        if (imem.addr !== prev_addr) begin
          miscompares++;
          $display("FAIL rnd_addr_stable cyc %0d: got %h, want %h", i, imem.addr, prev_addr);
        end
      end
      prev_instr = instr_out;
      prev_pc = pc_out;
      prev_valid = ifid_valid;
    end
    @(negedge Clk);
    Stall = 1'b0;
    JumpRegister = 1'b0;
    Jump = 1'b0;
    Branch = 1'b0;
    vectors++;
    if (loads < 100) begin
      miscompares++;
      $display("FAIL rnd_progress: got %0d loads, want at least 100", loads);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_priority();
    test_stall_redirect_flush();
    test_flush_load();
    test_wrap();
    test_ready_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
